mem_stage: RTL
==============

# mem_stage

Memory stage of the two-lane (ALU lane + MEM lane) VLIW pipeline, directly downstream of the EX stage. It consumes the EX/MEM register outputs and performs the MEM lane's byte load/store over a req/ack data-memory bus. It passes the ALU lane through unchanged, raises a stall while an access is outstanding, and owns the MEM/WB pipeline register.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 15: cycles in WAIT without `dmem_ack` before a fault is flagged (range 1–255).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `p4_pipeline_regWrite` in 1: MEM/WB register enable from hazard control.
- `MEM_flush` in 1: load a bubble into MEM/WB.
- `p3_valid` in 1: EX/MEM slot holds a real bundle.
- `p3_memRead`, `p3_memWrite`, `p3_alu_regWrite`, `p3_mem_regWrite` in 1 each: EX/MEM control.
- `p3_alu_rd`, `p3_mem_rd` in 3 each: destination registers.
- `p3_mem_reg_rd` in 8: store data byte.
- `p3_alu_aluOut`, `p3_mem_address` in 32 each.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32, `dmem_wdata` out 8: memory request.
- `dmem_ack` in 1, `dmem_rdata` in 8: memory response.
- `mem_stall` out 1: freeze PC, IF/ID, ID/EX, EX/MEM.
- `mem_fault` out 1: sticky timeout flag.
- `p4_valid`, `p4_alu_regWrite`, `p4_mem_regWrite` out 1 each.
- `p4_alu_rd`, `p4_mem_rd` out 3 each.
- `p4_alu_result`, `p4_mem_loadData` out 32 each.

## Operation
- Access needed: `acc = p3_valid & (p3_memRead | p3_memWrite)`. When both read and write are set, the write wins; the load is not done and `p4_mem_regWrite` is forced to 0.
- FSM states: IDLE, WAIT, FAULT.
  - IDLE: `dmem_req = acc` (combinational). If `acc & ~dmem_ack`, go to WAIT and clear the timer.
  - WAIT: hold `dmem_req = 1`. Address and data stay stable because EX/MEM is frozen. On `dmem_ack`, go to IDLE. The timer counts each WAIT cycle; when it reaches `TIMEOUT_CYCLES`, go to FAULT.
  - FAULT: `dmem_req = 0`, `mem_fault = 1`, `mem_stall = 1`. Leave only via reset.
- Request fields: `dmem_we = p3_memWrite`, `dmem_addr = p3_mem_address`, `dmem_wdata = p3_mem_reg_rd`.
- `mem_stall = (acc & ~dmem_ack & state != FAULT) | (state == FAULT)`.
- Load data: `p4_mem_loadData = {24'b0, dmem_rdata}`, captured on the ack cycle.
- MEM/WB update on a rising edge, when `p4_pipeline_regWrite = 1`:
  - If `MEM_flush` or `mem_stall`: load a bubble (`p4_valid` and both regWrites = 0; data fields keep their old values).
  - Otherwise: capture `p3_*`, with each regWrite ANDed with `p3_valid`.
- When `p4_pipeline_regWrite = 0`, MEM/WB holds its contents.
- The ALU lane passes through with no modification.

## Timing
- Reset values: every output is 0; state = IDLE; timer = 0; `mem_fault` = 0.
- Zero-wait access: ack in the same cycle as req gives no stall, and the result is in MEM/WB at the next edge.
- N-cycle ack: `mem_stall` is high for N cycles and MEM/WB receives N bubbles. Data is captured at the edge ending the ack cycle.
- `MEM_flush` during WAIT: the access completes anyway (a store is already committed to memory), but the result is loaded as a bubble.
- Reset mid-WAIT: `dmem_req` drops immediately (asynchronously). The memory must tolerate an abandoned request.
- `dmem_ack` while in IDLE with `acc = 0` is ignored.
- The timer is 8 bits and saturates; it never wraps.

## Structure
- Shared package: FSM state encoding (IDLE=2'd0, WAIT=2'd1, FAULT=2'd2) and the MEM/WB field widths (register address 3, data 32, store byte 8).
- One sub-module, `pipeline_MEM_WB`: the enable/flush register bank, mirroring the EX/MEM register style.
- The FSM and timer live in the top-level `mem_stage`.

## Test plan
- ALU-only bundle (`p3_alu_aluOut = 0x1234`, rd=3, no memory op) → no `dmem_req`; next cycle `p4_alu_result = 0x1234`, `p4_alu_rd = 3`, `p4_alu_regWrite = 1`.
- Load from 0x40 with ack 3 cycles late and `dmem_rdata = 0xA5` → `mem_stall` high for 3 cycles, 3 bubbles, then `p4_mem_loadData = 0x000000A5`.
- Store byte 0x7E to 0x10 with same-cycle ack → `dmem_we = 1`, `dmem_wdata = 0x7E`, no stall, `p4_mem_regWrite = 0`.
- `memRead` and `memWrite` both set → write issued; `p4_mem_regWrite = 0`.
- No ack with `TIMEOUT_CYCLES = 4` → FAULT after 4 WAIT cycles; `mem_fault` and `mem_stall` stay high until `reset = 0`, after which all outputs are 0.
- `MEM_flush` asserted in WAIT → after ack, `p4_valid = 0`; the store is still seen on the bus.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: FSM encoding, MEM/WB field widths and the
// MEM/WB payload layout used by the top and the pipeline register bank.
package mem_stage_pkg;

  localparam int unsigned REG_W   = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic              alu_reg_write;
    logic              mem_reg_write;
    logic [REG_W-1:0]  alu_rd;
    logic [REG_W-1:0]  mem_rd;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_load_data;
  } mem_wb_t;

  function automatic logic [DATA_W-1:0] zext_byte(input logic [BYTE_W-1:0] b);
    return {{(DATA_W-BYTE_W){1'b0}}, b};
  endfunction

  // A bubble kills the slot and its writebacks but leaves the data fields alone.
  function automatic mem_wb_t to_bubble(input mem_wb_t s);
    mem_wb_t r;
    r               = s;
    r.valid         = 1'b0;
    r.alu_reg_write = 1'b0;
    r.mem_reg_write = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_mem_wb.sv
// MEM/WB pipeline register bank: enable holds, bubble kills the slot,
// otherwise the incoming bundle is captured.
module pipeline_MEM_WB
  import mem_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en_i,
  input  logic    bubble_i,
  input  mem_wb_t d_i,
  output mem_wb_t q_o
);

  mem_wb_t q_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= bubble_i ? to_bubble(q_q) : d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the two-lane VLIW pipeline: byte load/store over a req/ack
// bus with a timeout FSM, stall generation and the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p4_pipeline_regWrite,
  input  logic              MEM_flush,
  input  logic              p3_valid,
  input  logic              p3_memRead,
  input  logic              p3_memWrite,
  input  logic              p3_alu_regWrite,
  input  logic              p3_mem_regWrite,
  input  logic [REG_W-1:0]  p3_alu_rd,
  input  logic [REG_W-1:0]  p3_mem_rd,
  input  logic [BYTE_W-1:0] p3_mem_reg_rd,
  input  logic [DATA_W-1:0] p3_alu_aluOut,
  input  logic [DATA_W-1:0] p3_mem_address,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [BYTE_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [BYTE_W-1:0] dmem_rdata,
  output logic              mem_stall,
  output logic              mem_fault,
  output logic              p4_valid,
  output logic              p4_alu_regWrite,
  output logic              p4_mem_regWrite,
  output logic [REG_W-1:0]  p4_alu_rd,
  output logic [REG_W-1:0]  p4_mem_rd,
  output logic [DATA_W-1:0] p4_alu_result,
  output logic [DATA_W-1:0] p4_mem_loadData
);

  localparam logic [TIMER_W-1:0] TIMEOUT_LIMIT = TIMER_W'(TIMEOUT_CYCLES);

  state_e             state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_inc;
  logic               acc;
  mem_wb_t            wb_d;
  mem_wb_t            wb_q;

  assign acc       = p3_valid & (p3_memRead | p3_memWrite);
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc && !dmem_ack) begin
            state_q <= WAIT;
            timer_q <= '0;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            state_q <= IDLE;
          end else begin
            timer_q <= timer_inc;
            if (timer_inc >= TIMEOUT_LIMIT) state_q <= FAULT;
          end
        end
        FAULT:   state_q <= FAULT;
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  // Gating with reset makes a request abandoned by reset drop immediately.
  always_comb begin
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          dmem_req  = acc;
          mem_stall = acc & ~dmem_ack;
        end
        WAIT: begin
          dmem_req  = 1'b1;
          mem_stall = acc & ~dmem_ack;
        end
        FAULT: begin
          dmem_req  = 1'b0;
          mem_stall = 1'b1;
        end
        default: begin
          dmem_req  = 1'b0;
          mem_stall = 1'b0;
        end
      endcase
    end
  end

  assign mem_fault  = (state_q == FAULT);
  assign dmem_we    = p3_memWrite;
  assign dmem_addr  = p3_mem_address;
  assign dmem_wdata = p3_mem_reg_rd;

  // A bundle with both read and write set is treated as a store: no load writeback.
  always_comb begin
    wb_d               = '0;
    wb_d.valid         = p3_valid;
    wb_d.alu_reg_write = p3_alu_regWrite & p3_valid;
    wb_d.mem_reg_write = p3_mem_regWrite & p3_valid & ~(p3_memRead & p3_memWrite);
    wb_d.alu_rd        = p3_alu_rd;
    wb_d.mem_rd        = p3_mem_rd;
    wb_d.alu_result    = p3_alu_aluOut;
    wb_d.mem_load_data = zext_byte(dmem_rdata);
  end

  pipeline_MEM_WB u_mem_wb (
    .clk      (clk),
    .rst_n    (reset),
    .en_i     (p4_pipeline_regWrite),
    .bubble_i (MEM_flush | mem_stall),
    .d_i      (wb_d),
    .q_o      (wb_q)
  );

  assign p4_valid        = wb_q.valid;
  assign p4_alu_regWrite = wb_q.alu_reg_write;
  assign p4_mem_regWrite = wb_q.mem_reg_write;
  assign p4_alu_rd       = wb_q.alu_rd;
  assign p4_mem_rd       = wb_q.mem_rd;
  assign p4_alu_result   = wb_q.alu_result;
  assign p4_mem_loadData = wb_q.mem_load_data;

endmodule
